// File: rtl/resv_pkg.sv
// Shared reservation-station definitions: station geometry, field widths and
// the reserved "no cell" / "unused op" codes used by every station block.
package resv_pkg;

  localparam int unsigned resv_n_cell  = 8;
  localparam int unsigned resv_w_ident = 4;
  localparam int unsigned resv_w_uops  = 6;
  localparam int unsigned resv_w_rx_a  = 5;
  localparam int unsigned resv_w_rx_d  = 32;
  localparam int unsigned resv_w_imm_d = 32;
  localparam int unsigned resv_w_pc_d  = 32;

  // Ident value meaning "no cell selected"
  localparam logic [resv_w_ident-1:0] resv_unused_cd = 4'b1111;
  // Op code parked in an empty issue register
  localparam logic [resv_w_uops-1:0]  resv_unused_op = '1;

endpackage

// File: rtl/resv_pick_oldest.sv
// Priority picker: returns the lowest cell index whose candidate code is not
// the "no cell" code; returns the "no cell" code when nothing is offered.
// Ports:
//   candit_all_i  N_cell slices of W_ident, slice k from cell k (0 = oldest)
//   pick_o        selected cell index, or unused_cd
module resv_pick_oldest
  import resv_pkg::*;
#(
  parameter int unsigned        N_cell    = resv_n_cell,
  parameter int unsigned        W_ident   = resv_w_ident,
  parameter logic [W_ident-1:0] unused_cd = W_ident'(resv_unused_cd)
) (
  input  logic [N_cell*W_ident-1:0] candit_all_i,
  output logic [W_ident-1:0]        pick_o
);

  // Scan from youngest to oldest so the oldest candidate wins
  always_comb begin
    pick_o = unused_cd;
    for (int k = N_cell - 1; k >= 0; k--) begin
      if (candit_all_i[k*W_ident +: W_ident] != unused_cd) begin
        pick_o = W_ident'(k);
      end
    end
  end

endmodule

// File: rtl/resv_issue_pip0.sv
// Pipe0 issue stage of the reservation station: picks the oldest pipe0
// candidate, registers its contents into the issue register under a
// valid/ready handshake, tracks station occupancy and steers the shift and
// insert addresses of the cell array.
// Ports:
//   clk, clear        clock; synchronous active-high reset / station flush
//   candit0_all       per-cell pip0 candidate codes
//   sel_a, sel_*      read-port cell select and the selected cell's contents
//   addr_shift        lowest cell that takes shift input (unused_cd = none)
//   addr_insert       cell receiving the decoder entry (unused_cd = none)
//   dec_valid/ready   decoder handshake
//   iss_valid/ready   pipe0 handshake, iss_* registered op
//   occ               occupied-cell count
module resv_issue_pip0
  import resv_pkg::*;
#(
  parameter int unsigned        N_cell    = resv_n_cell,
  parameter int unsigned        W_ident   = resv_w_ident,
  parameter logic [W_ident-1:0] unused_cd = W_ident'(resv_unused_cd),
  parameter int unsigned        W_uops    = resv_w_uops,
  parameter int unsigned        W_rx_a    = resv_w_rx_a,
  parameter int unsigned        W_rx_d    = resv_w_rx_d,
  parameter int unsigned        W_imm_d   = resv_w_imm_d,
  parameter int unsigned        W_pc_d    = resv_w_pc_d
) (
  input  logic                      clk,
  input  logic                      clear,
  input  logic [N_cell*W_ident-1:0] candit0_all,
  output logic [W_ident-1:0]        sel_a,
  input  logic [W_uops-1:0]         sel_uops,
  input  logic [W_rx_a-1:0]         sel_rd_a,
  input  logic [W_rx_d-1:0]         sel_rs_d,
  input  logic [W_rx_d-1:0]         sel_rt_d,
  input  logic [W_imm_d-1:0]        sel_imm_d,
  input  logic [W_pc_d-1:0]         sel_pc_d,
  output logic [W_ident-1:0]        addr_shift,
  output logic [W_ident-1:0]        addr_insert,
  input  logic                      dec_valid,
  output logic                      dec_ready,
  output logic                      iss_valid,
  input  logic                      iss_ready,
  output logic [W_uops-1:0]         iss_uops,
  output logic [W_rx_a-1:0]         iss_rd_a,
  output logic [W_rx_d-1:0]         iss_rs_d,
  output logic [W_rx_d-1:0]         iss_rt_d,
  output logic [W_imm_d-1:0]        iss_imm_d,
  output logic [W_pc_d-1:0]         iss_pc_d,
  output logic [W_ident-1:0]        occ
);

  localparam logic [W_ident-1:0] n_cell_c    = W_ident'(N_cell);
  localparam logic [W_uops-1:0]  unused_op_c = W_uops'(resv_unused_op);

  logic [W_ident-1:0]        occ_q, occ_d;
  logic                      iss_valid_q, iss_valid_d;
  logic [W_uops-1:0]         iss_uops_q;
  logic [W_rx_a-1:0]         iss_rd_a_q;
  logic [W_rx_d-1:0]         iss_rs_d_q, iss_rt_d_q;
  logic [W_imm_d-1:0]        iss_imm_d_q;
  logic [W_pc_d-1:0]         iss_pc_d_q;
  logic [N_cell*W_ident-1:0] candit_live;
  logic                      ld, fire, ins;

  // Cells at or above occ are empty; their candidate codes are stale
  always_comb begin
    candit_live = candit0_all;
    for (int k = 0; k < N_cell; k++) begin
      if (W_ident'(k) >= occ_q) begin
        candit_live[k*W_ident +: W_ident] = unused_cd;
      end
    end
  end

  resv_pick_oldest #(
    .N_cell    (N_cell),
    .W_ident   (W_ident),
    .unused_cd (unused_cd)
  ) u_pick (
    .candit_all_i (candit_live),
    .pick_o       (sel_a)
  );

  // Handshakes; a flush suppresses both issue and insert
  assign ld        = !iss_valid_q || iss_ready;
  assign fire      = !clear && ld && (sel_a != unused_cd);
  assign dec_ready = !clear && (occ_q < n_cell_c);
  assign ins       = dec_valid && dec_ready;

  assign addr_shift = fire ? sel_a : unused_cd;

  // When a cell issues the same cycle, everything above it shifts down one,
  // so the new entry lands one slot lower
  always_comb begin
    addr_insert = unused_cd;
    if (ins) begin
      addr_insert = fire ? (occ_q - W_ident'(1)) : occ_q;
    end
  end

  always_comb begin
    occ_d       = occ_q + W_ident'(ins) - W_ident'(fire);
    iss_valid_d = iss_valid_q;
    if (fire) begin
      iss_valid_d = 1'b1;
    end else if (ld) begin
      iss_valid_d = 1'b0;
    end
  end

  // Occupancy and issue register
  always_ff @(posedge clk) begin
    if (clear) begin
      occ_q       <= '0;
      iss_valid_q <= 1'b0;
      iss_uops_q  <= unused_op_c;
      iss_rd_a_q  <= '0;
      iss_rs_d_q  <= '0;
      iss_rt_d_q  <= '0;
      iss_imm_d_q <= '0;
      iss_pc_d_q  <= '0;
    end else begin
      occ_q       <= occ_d;
      iss_valid_q <= iss_valid_d;
      if (fire) begin
        iss_uops_q  <= sel_uops;
        iss_rd_a_q  <= sel_rd_a;
        iss_rs_d_q  <= sel_rs_d;
        iss_rt_d_q  <= sel_rt_d;
        iss_imm_d_q <= sel_imm_d;
        iss_pc_d_q  <= sel_pc_d;
      end
    end
  end

  assign occ       = occ_q;
  assign iss_valid = iss_valid_q;
  assign iss_uops  = iss_uops_q;
  assign iss_rd_a  = iss_rd_a_q;
  assign iss_rs_d  = iss_rs_d_q;
  assign iss_rt_d  = iss_rt_d_q;
  assign iss_imm_d = iss_imm_d_q;
  assign iss_pc_d  = iss_pc_d_q;

endmodule

// File: tb/tb_resv_issue_pip0.sv
// Bench for resv_issue_pip0: directed scenarios followed by random traffic,
// all compared against a behavioural station model.
module tb_resv_issue_pip0;

  localparam int unsigned N  = 8;
  localparam int unsigned WI = 4;
  localparam int unsigned WU = 6;
  localparam int unsigned WA = 5;
  localparam int unsigned WD = 32;
  localparam logic [WI-1:0] UNU = 4'b1111;

  logic            clk = 1'b0;
  logic            clear, dec_valid, iss_ready;
  logic [N*WI-1:0] candit0_all;
  logic [WI-1:0]   sel_a, addr_shift, addr_insert, occ;
  logic [WU-1:0]   sel_uops, iss_uops;
  logic [WA-1:0]   sel_rd_a, iss_rd_a;
  logic [WD-1:0]   sel_rs_d, sel_rt_d, sel_imm_d, sel_pc_d;
  logic [WD-1:0]   iss_rs_d, iss_rt_d, iss_imm_d, iss_pc_d;
  logic            dec_ready, iss_valid;

  always #5 clk = ~clk;

  resv_issue_pip0 dut (
    .clk(clk), .clear(clear), .candit0_all(candit0_all), .sel_a(sel_a),
    .sel_uops(sel_uops), .sel_rd_a(sel_rd_a), .sel_rs_d(sel_rs_d),
    .sel_rt_d(sel_rt_d), .sel_imm_d(sel_imm_d), .sel_pc_d(sel_pc_d),
    .addr_shift(addr_shift), .addr_insert(addr_insert),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_uops(iss_uops), .iss_rd_a(iss_rd_a), .iss_rs_d(iss_rs_d),
    .iss_rt_d(iss_rt_d), .iss_imm_d(iss_imm_d), .iss_pc_d(iss_pc_d),
    .occ(occ)
  );

  // Cell contents seen through the read port
  logic [WU-1:0] st_uops [N];
  logic [WA-1:0] st_rd_a [N];
  logic [WD-1:0] st_rs [N], st_rt [N], st_imm [N], st_pc [N];

  always_comb begin
    sel_uops = '0; sel_rd_a = '0; sel_rs_d = '0;
    sel_rt_d = '0; sel_imm_d = '0; sel_pc_d = '0;
    if (sel_a < 4'(N)) begin
      sel_uops  = st_uops[sel_a[2:0]];
      sel_rd_a  = st_rd_a[sel_a[2:0]];
      sel_rs_d  = st_rs[sel_a[2:0]];
      sel_rt_d  = st_rt[sel_a[2:0]];
      sel_imm_d = st_imm[sel_a[2:0]];
      sel_pc_d  = st_pc[sel_a[2:0]];
    end
  end

  // Model state (mo_*) and its value after the coming edge (mn_*)
  int            mo_occ, mn_occ;
  bit            mo_vld, mn_vld;
  logic [WU-1:0] mo_uops, mn_uops;
  logic [WA-1:0] mo_rd, mn_rd;
  logic [WD-1:0] mo_rs, mn_rs, mo_rt, mn_rt, mo_imm, mn_imm, mo_pc, mn_pc;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N*WI-1:0] cands(input logic [N-1:0] m);
    logic [N*WI-1:0] v;
    for (int k = 0; k < N; k++)
      v[k*WI +: WI] = m[k] ? 4'($urandom_range(0, 14)) : UNU;
    return v;
  endfunction

  // Drive one cycle's inputs, compare everything, and work out the next state
  task automatic apply(input bit clr, input bit dv, input bit ir, input logic [N*WI-1:0] c);
    logic [WI-1:0] e_pick, e_ins_a;
    bit e_ld, e_fire, e_rdy, e_ins;
    clear = clr; dec_valid = dv; iss_ready = ir; candit0_all = c;
    for (int k = 0; k < N; k++) begin
      st_uops[k] = WU'($urandom); st_rd_a[k] = WA'($urandom);
      st_rs[k] = $urandom; st_rt[k] = $urandom;
      st_imm[k] = $urandom; st_pc[k] = $urandom;
    end
    #1;
    e_pick = UNU;
    for (int k = 0; k < N; k++)
      if (e_pick == UNU && k < mo_occ && c[k*WI +: WI] != UNU) e_pick = 4'(k);
    e_ld   = !mo_vld || ir;
    e_fire = !clr && e_ld && (e_pick != UNU);
    e_rdy  = !clr && (mo_occ < N);
    e_ins  = dv && e_rdy;
    e_ins_a = UNU;
    if (e_ins) e_ins_a = e_fire ? 4'(mo_occ - 1) : 4'(mo_occ);

    check("sel_a", 64'(sel_a), 64'(e_pick));
    check("addr_shift", 64'(addr_shift), 64'(e_fire ? e_pick : UNU));
    check("addr_insert", 64'(addr_insert), 64'(e_ins_a));
    check("dec_ready", 64'(dec_ready), 64'(e_rdy));
    check("occ", 64'(occ), 64'(mo_occ));
    check("iss_valid", 64'(iss_valid), 64'(mo_vld));
    check("iss_uops", 64'(iss_uops), 64'(mo_uops));
    check("iss_rd_a", 64'(iss_rd_a), 64'(mo_rd));
    check("iss_rs_d", 64'(iss_rs_d), 64'(mo_rs));
    check("iss_rt_d", 64'(iss_rt_d), 64'(mo_rt));
    check("iss_imm_d", 64'(iss_imm_d), 64'(mo_imm));
    check("iss_pc_d", 64'(iss_pc_d), 64'(mo_pc));

    mn_occ = mo_occ; mn_vld = mo_vld; mn_uops = mo_uops; mn_rd = mo_rd;
    mn_rs = mo_rs; mn_rt = mo_rt; mn_imm = mo_imm; mn_pc = mo_pc;
    if (clr) begin
      mn_occ = 0; mn_vld = 0; mn_uops = '1;
      mn_rd = '0; mn_rs = '0; mn_rt = '0; mn_imm = '0; mn_pc = '0;
    end else begin
      mn_occ = mo_occ + int'(e_ins) - int'(e_fire);
      if (e_fire) begin
        mn_vld = 1;
        mn_uops = st_uops[e_pick[2:0]]; mn_rd = st_rd_a[e_pick[2:0]];
        mn_rs = st_rs[e_pick[2:0]]; mn_rt = st_rt[e_pick[2:0]];
        mn_imm = st_imm[e_pick[2:0]]; mn_pc = st_pc[e_pick[2:0]];
      end else if (e_ld) begin
        mn_vld = 0;
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    mo_occ = mn_occ; mo_vld = mn_vld; mo_uops = mn_uops; mo_rd = mn_rd;
    mo_rs = mn_rs; mo_rt = mn_rt; mo_imm = mn_imm; mo_pc = mn_pc;
    @(negedge clk);
  endtask

  task automatic cyc(input bit clr, input bit dv, input bit ir, input logic [N*WI-1:0] c);
    apply(clr, dv, ir, c);
    adv();
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 1, '1);
  endtask

  logic [WU-1:0] saved_uops;

  initial begin
    // Unchecked power-up flush
    clear = 1; dec_valid = 0; iss_ready = 0; candit0_all = '1;
    @(posedge clk);
    @(negedge clk);
    mo_occ = 0; mo_vld = 0; mo_uops = '1;
    mo_rd = '0; mo_rs = '0; mo_rt = '0; mo_imm = '0; mo_pc = '0;

    // Reset cycle
    apply(1, 1, 1, '1);
    check("rst_dec_ready", 64'(dec_ready), 64'(0));
    check("rst_shift", 64'(addr_shift), 64'(UNU));
    check("rst_insert", 64'(addr_insert), 64'(UNU));
    adv();
    apply(0, 0, 1, '1);
    check("rst_occ", 64'(occ), 64'(0));
    check("rst_iss_valid", 64'(iss_valid), 64'(0));
    check("rst_dec_ready_after", 64'(dec_ready), 64'(1));
    adv();

    // Fill to full
    for (int i = 0; i < 8; i++) begin
      apply(0, 1, 1, '1);
      check("fill_insert", 64'(addr_insert), 64'(i));
      adv();
    end
    apply(0, 1, 1, '1);
    check("full_occ", 64'(occ), 64'(8));
    check("full_dec_ready", 64'(dec_ready), 64'(0));
    check("full_insert", 64'(addr_insert), 64'(UNU));
    adv();

    // Oldest pick among cells 3 and 1
    cyc(1, 0, 1, '1);
    fill(5);
    apply(0, 0, 1, cands(8'b0000_1010));
    check("pick_sel_a", 64'(sel_a), 64'(1));
    check("pick_shift", 64'(addr_shift), 64'(1));
    saved_uops = st_uops[1];
    adv();
    apply(0, 0, 0, '1);
    check("pick_iss_valid", 64'(iss_valid), 64'(1));
    check("pick_iss_uops", 64'(iss_uops), 64'(saved_uops));
    check("pick_occ", 64'(occ), 64'(4));
    adv();

    // Backpressure then release
    apply(0, 0, 0, cands(8'b0000_0001));
    check("bp_shift", 64'(addr_shift), 64'(UNU));
    adv();
    apply(0, 0, 1, cands(8'b0000_0001));
    check("bp_release_shift", 64'(addr_shift), 64'(0));
    adv();

    // Insert and issue in the same cycle
    cyc(1, 0, 1, '1);
    fill(4);
    apply(0, 1, 1, cands(8'b0000_0100));
    check("sim_shift", 64'(addr_shift), 64'(2));
    check("sim_insert", 64'(addr_insert), 64'(3));
    adv();
    apply(0, 0, 0, '1);
    check("sim_occ", 64'(occ), 64'(4));
    adv();

    // Flush while issue and insert are pending
    cyc(1, 0, 1, '1);
    fill(7);
    cyc(0, 0, 1, cands(8'b0000_0001));
    apply(1, 1, 1, cands(8'b0000_0001));
    check("clr_occ_before", 64'(occ), 64'(6));
    check("clr_shift", 64'(addr_shift), 64'(UNU));
    check("clr_insert", 64'(addr_insert), 64'(UNU));
    adv();
    apply(0, 0, 0, '1);
    check("clr_occ", 64'(occ), 64'(0));
    check("clr_iss_valid", 64'(iss_valid), 64'(0));
    check("clr_iss_uops", 64'(iss_uops), 64'(6'h3f));
    adv();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 6,
          $urandom_range(0, 9) < 7, cands(8'($urandom) & 8'($urandom)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/resv_issue_pip0.md
RESV_ISSUE_PIP0 -- requirements
Module: resv_issue_pip0

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  N_cell, 8, reservation-station cells, idents 0..N_cell-1, index 0 oldest
  W_ident, 4, cell ident width
  unused_cd, 4'b1111, "no cell" code
  W_uops, 6, micro-op width
  W_rx_a, 5, register address width
  W_rx_d, 32, register data width
  W_imm_d, 32, immediate width
  W_pc_d, 32, PC width
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  single clock
  clear  in  1  reset, synchronous, active-high; also station flush
  candit0_all  in  N_cell*W_ident  per-cell pip0 candidate codes, slice k from cell k
  sel_a  out  W_ident  read-port cell select
  sel_uops/sel_rd_a/sel_rs_d/sel_rt_d/sel_imm_d/sel_pc_d  in  field widths  selected cell contents, combinational
  addr_shift  out  W_ident  cell ident at and above which cells take shift input
  addr_insert  out  W_ident  cell receiving the decoder entry
  dec_valid  in  1  decoder offers an entry
  dec_ready  out  1  station accepts an entry
  iss_valid  out  1  issue register holds an op for pipe0
  iss_ready  in  1  pipe0 accepts the op
  iss_uops/iss_rd_a/iss_rs_d/iss_rt_d/iss_imm_d/iss_pc_d  out  field widths  issued op
  occ  out  W_ident  occupied-cell count, 0..N_cell

Function
REQ-003 Pick: sel_a SHALL be the lowest k whose candit0 slice is not unused_cd; unused_cd when no such k.
REQ-004 Issue stage load enable SHALL be ld = !iss_valid || iss_ready.
REQ-005 Issue fire SHALL be fire = ld && sel_a != unused_cd; on fire, iss_* SHALL capture sel_* at that clk edge and iss_valid SHALL be 1 next cycle (latency 1 from candidate to iss_valid).
REQ-006 On ld without fire, iss_valid SHALL go 0; without ld, iss_* and iss_valid SHALL hold.
REQ-007 addr_shift SHALL be sel_a when fire, else unused_cd.
REQ-008 dec_ready SHALL be 1 iff occ < N_cell; a full station with simultaneous fire SHALL still show dec_ready 0.
REQ-009 Insert SHALL be ins = dec_valid && dec_ready; addr_insert SHALL be occ-1 when ins && fire, occ when ins && !fire, else unused_cd.
REQ-010 occ SHALL update as occ + ins - fire, width-safe, never exceeding N_cell or going below 0.
REQ-011 A candidate slice with ident >= occ SHALL be ignored.
REQ-012 All outputs other than iss_* data SHALL be functions of registered state and current inputs only; no combinational path from iss_ready to iss_* data.

Reset
REQ-013 On clk edge with clear=1: occ SHALL become 0, iss_valid 0, iss_uops all-ones (unused op), other iss_* data 0; clear SHALL win over fire and ins in the same cycle.
REQ-014 During clear cycle, addr_shift and addr_insert SHALL be unused_cd and dec_ready 0.

Structure
REQ-015 N_cell, all widths, unused_cd and unused_op SHALL live in shared package resv_pkg, used by all reservation-station blocks.
REQ-016 Priority pick SHALL be sub-module resv_pick_oldest (N_cell slices in, W_ident index out).

Verification
REQ-017 Reset: clear=1 one cycle -> occ=0, iss_valid=0, dec_ready=0 then 1, addr_shift=addr_insert=4'b1111.
REQ-018 Fill: dec_valid=1 for 9 cycles, no candidates -> addr_insert 0..7, occ=8, dec_ready=0 on cycle 9, addr_insert=4'b1111.
REQ-019 Oldest pick: occ=5, candidates at cells 3 and 1, iss_ready=1 -> sel_a=1, addr_shift=1, iss_valid next cycle with cell-1 data, occ=4.
REQ-020 Backpressure: iss_valid=1, iss_ready=0, candidate at cell 0 -> no fire, addr_shift=4'b1111, iss_* hold; iss_ready=1 -> fire same cycle.
REQ-021 Simultaneous: occ=4, fire cell 2, dec_valid=1 -> addr_shift=2, addr_insert=3, occ stays 4.
REQ-022 Clear mid-operation: occ=6, iss_valid=1, fire and ins pending, clear=1 -> occ=0, iss_valid=0 next cycle, no insert or shift.
